// File: rtl/pcint_pkg.sv
// Shared constants for the pin-change interrupt groups.
// Addresses, group bit positions and per-group pin counts.
package pcint_pkg;

  localparam logic [5:0] PCIFR_IO_ADR  = 6'h1B;
  localparam logic [7:0] PCICR_RAM_ADR = 8'h68;
  localparam logic [7:0] PCMSK0_RAM_ADR = 8'h6B;
  localparam logic [7:0] PCMSK_RAM_ADR = 8'h6C;
  localparam logic [7:0] PCMSK2_RAM_ADR = 8'h6D;
  localparam logic [7:0] PCMSK3_RAM_ADR = 8'h73;

  localparam int PCIE0_BIT = 0;
  localparam int PCIE1_BIT = 1;
  localparam int PCIE2_BIT = 2;
  localparam int PCIE3_BIT = 3;

  localparam int N_PINS_G0 = 8;
  localparam int N_PINS_G1 = 7;
  localparam int N_PINS_G2 = 8;
  localparam int N_PINS_G3 = 4;

  function automatic logic [7:0] bit_at(
    input logic v,
    input int   pos
  );
    logic [7:0] r;
    r = '0;
    r[pos[2:0]] = v;
    return r;
  endfunction

endpackage

// File: rtl/pcint_ctrl_c_if.sv
// Core-side I/O and extended-I/O register bus.
// master = core, slave = peripheral.
interface pcint_ctrl_c_if;

  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic [7:0] ram_dbus_out;
  logic       ram_out_en;

  modport master (
    output IO_Addr, iore, iowe, dbus_in,
    output ramadr, ramre, ramwe,
    input  dbus_out, out_en,
    input  ram_dbus_out, ram_out_en
  );

  modport slave (
    input  IO_Addr, iore, iowe, dbus_in,
    input  ramadr, ramre, ramwe,
    output dbus_out, out_en,
    output ram_dbus_out, ram_out_en
  );

endinterface

// File: rtl/pcint_sync.sv
// N-bit multi-stage input synchronizer.
// Async active-high reset clears every stage.
module pcint_sync #(
  parameter int N      = 7,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [STAGES-1:0][N-1:0] stg_q;
  logic [STAGES-1:0][N-1:0] stg_d;

  always_comb begin
    stg_d    = stg_q;
    stg_d[0] = d_i;
    for (int i = 1; i < STAGES; i++)
      stg_d[i] = stg_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg_q <= '0;
    else     stg_q <= stg_d;
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/pcint_ctrl_c.sv
// Pin-change interrupt controller, Port C group.
// Owns PCMSK1, PCIE1 and PCIF1; raises irq to the core.
module pcint_ctrl_c #(
  parameter int         N_PINS        = pcint_pkg::N_PINS_G1,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [5:0] PCIFR_IO_ADR  = pcint_pkg::PCIFR_IO_ADR,
  parameter logic [7:0] PCICR_RAM_ADR = pcint_pkg::PCICR_RAM_ADR,
  parameter logic [7:0] PCMSK_RAM_ADR = pcint_pkg::PCMSK_RAM_ADR,
  parameter int         PCIE_BIT      = pcint_pkg::PCIE1_BIT
) (
  input  logic              cp2,
  input  logic              ireset,
  pcint_ctrl_c_if.slave     bus,
  input  logic [N_PINS-1:0] DIC_i,
  output logic [N_PINS-1:0] PCINT_o,
  output logic              PCIE_o,
  output logic              irq,
  input  logic              irq_ack
);

  import pcint_pkg::*;

  logic [N_PINS-1:0] s;
  logic [N_PINS-1:0] prev_q, prev_d;
  logic [N_PINS-1:0] pcmsk_q, pcmsk_d;
  logic [N_PINS-1:0] chg;
  logic              pcie_q, pcie_d;
  logic              pcif_q, pcif_d;
  logic              sel_io, sel_cr, sel_msk;
  logic              w1c;
  logic              io_en, ram_en;
  logic [7:0]        io_dat, ram_dat;
  logic              unused_dbus;

  pcint_sync #(
    .N      (N_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (cp2),
    .rst (ireset),
    .d_i (DIC_i),
    .q_o (s)
  );

  assign sel_io  = (bus.IO_Addr == PCIFR_IO_ADR);
  assign sel_cr  = (bus.ramadr == PCICR_RAM_ADR);
  assign sel_msk = (bus.ramadr == PCMSK_RAM_ADR);
  assign unused_dbus = ^bus.dbus_in;

  always_comb begin
    pcmsk_d = pcmsk_q;
    pcie_d  = pcie_q;
    prev_d  = s;
    chg     = (s ^ prev_q) & pcmsk_q;
    w1c     = bus.iowe && sel_io && bus.dbus_in[PCIE_BIT];
    if (bus.ramwe && sel_msk)
      pcmsk_d = bus.dbus_in[N_PINS-1:0];
    if (bus.ramwe && sel_cr)
      pcie_d = bus.dbus_in[PCIE_BIT];
    // a new edge wins over any clear in the same cycle
    pcif_d = pcif_q;
    if (|chg)
      pcif_d = 1'b1;
    else if (w1c || irq_ack)
      pcif_d = 1'b0;
  end

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      prev_q  <= '0;
      pcmsk_q <= '0;
      pcie_q  <= 1'b0;
      pcif_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pcmsk_q <= pcmsk_d;
      pcie_q  <= pcie_d;
      pcif_q  <= pcif_d;
    end
  end

  always_comb begin
    io_en   = bus.iore && sel_io;
    ram_en  = bus.ramre && (sel_cr || sel_msk);
    io_dat  = '0;
    ram_dat = '0;
    if (io_en)
      io_dat = bit_at(pcif_q, PCIE_BIT);
    if (bus.ramre && sel_msk)
      ram_dat = 8'(pcmsk_q);
    else if (bus.ramre && sel_cr)
      ram_dat = bit_at(pcie_q, PCIE_BIT);
  end

  assign bus.out_en       = io_en;
  assign bus.dbus_out     = io_dat;
  assign bus.ram_out_en   = ram_en;
  assign bus.ram_dbus_out = ram_dat;

  assign PCINT_o = pcmsk_q;
  assign PCIE_o  = pcie_q;
  assign irq     = pcif_q & pcie_q;

endmodule

// File: tb/tb_pcint_ctrl_c.sv
// Scoreboarded bench for pcint_ctrl_c.
// Reads push expectations; a monitor checks bus output.
module tb_pcint_ctrl_c;

  logic       cp2;
  logic       ireset;
  logic [6:0] DIC_i;
  logic [6:0] PCINT_o;
  logic       PCIE_o;
  logic       irq;
  logic       irq_ack;

  int n_chk;
  int n_fail;

  logic [7:0] io_q[$];
  logic [7:0] ram_q[$];

  pcint_ctrl_c_if bus();

  pcint_ctrl_c dut (
    .cp2     (cp2),
    .ireset  (ireset),
    .bus     (bus),
    .DIC_i   (DIC_i),
    .PCINT_o (PCINT_o),
    .PCIE_o  (PCIE_o),
    .irq     (irq),
    .irq_ack (irq_ack)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  always @(negedge cp2) begin
    logic [7:0] e;
    if (bus.out_en) begin
      n_chk++;
      if (io_q.size() == 0) begin
        n_fail++;
        $display("FAIL io_rd unexpected: got %h required none",
                 bus.dbus_out);
      end else begin
        e = io_q.pop_front();
        if (bus.dbus_out !== e) begin
          n_fail++;
          $display("FAIL io_rd: got %h required %h",
                   bus.dbus_out, e);
        end
      end
    end
    if (bus.ram_out_en) begin
      n_chk++;
      if (ram_q.size() == 0) begin
        n_fail++;
        $display("FAIL ram_rd unexpected: got %h required none",
                 bus.ram_dbus_out);
      end else begin
        e = ram_q.pop_front();
        if (bus.ram_dbus_out !== e) begin
          n_fail++;
          $display("FAIL ram_rd: got %h required %h",
                   bus.ram_dbus_out, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge cp2);
    #1;
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
    bus.ramadr  = a;
    bus.dbus_in = d;
    bus.ramwe   = 1'b1;
    tick(1);
    bus.ramwe   = 1'b0;
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    bus.IO_Addr = a;
    bus.dbus_in = d;
    bus.iowe    = 1'b1;
    tick(1);
    bus.iowe    = 1'b0;
  endtask

  task automatic ram_rd(input logic [7:0] a, input logic [7:0] e);
    ram_q.push_back(e);
    bus.ramadr = a;
    bus.ramre  = 1'b1;
    @(negedge cp2);
    #1;
    bus.ramre  = 1'b0;
    tick(1);
  endtask

  task automatic io_rd(input logic [7:0] e);
    io_q.push_back(e);
    bus.IO_Addr = 6'h1B;
    bus.iore    = 1'b1;
    @(negedge cp2);
    #1;
    bus.iore    = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    ireset = 1'b1;
    DIC_i = '0;
    irq_ack = 1'b0;
    bus.IO_Addr = '0;
    bus.iore = 1'b0;
    bus.iowe = 1'b0;
    bus.dbus_in = '0;
    bus.ramadr = '0;
    bus.ramre = 1'b0;
    bus.ramwe = 1'b0;

    #12;
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_pcint", 8'(PCINT_o), 8'h00);
    chk("rst_pcie", 8'(PCIE_o), 8'h00);
    chk("rst_out_en", 8'(bus.out_en), 8'h00);
    chk("rst_dbus_out", bus.dbus_out, 8'h00);
    chk("rst_ram_dbus", bus.ram_dbus_out, 8'h00);
    tick(1);
    ireset = 1'b0;
    tick(2);

    // mask write and readback
    ram_wr(8'h6C, 8'h55);
    ram_rd(8'h6C, 8'h55);
    chk("pcint_o_55", 8'(PCINT_o), 8'h55);
    io_rd(8'h00);

    // masked edge, 3-edge latency
    ram_wr(8'h6C, 8'h01);
    ram_wr(8'h68, 8'h02);
    chk("pcie_o_on", 8'(PCIE_o), 8'h01);
    DIC_i = 7'h01;
    tick(1);
    chk("lat_e1", 8'(irq), 8'h00);
    tick(1);
    chk("lat_e2", 8'(irq), 8'h00);
    tick(1);
    chk("lat_e3", 8'(irq), 8'h01);
    io_rd(8'h02);
    io_wr(6'h1B, 8'h02);
    chk("w1c_irq", 8'(irq), 8'h00);

    // unmasked pin toggle
    DIC_i = 7'h41;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("unmasked_irq", 8'(irq), 8'h00);
    end
    io_rd(8'h00);

    // enable gating, write-zero and W1C
    ram_wr(8'h68, 8'h00);
    chk("pcie_o_off", 8'(PCIE_o), 8'h00);
    DIC_i = 7'h40;
    tick(4);
    chk("gated_irq", 8'(irq), 8'h00);
    io_rd(8'h02);
    io_wr(6'h1B, 8'h00);
    io_rd(8'h02);
    ram_wr(8'h68, 8'h02);
    chk("enable_irq", 8'(irq), 8'h01);
    ram_rd(8'h68, 8'h02);
    io_wr(6'h1B, 8'h02);
    chk("w1c_clr_irq", 8'(irq), 8'h00);
    io_rd(8'h00);

    // set vs. ack + W1C in the same cycle
    DIC_i = 7'h41;
    tick(2);
    chk("simul_pre", 8'(irq), 8'h00);
    bus.IO_Addr = 6'h1B;
    bus.dbus_in = 8'h02;
    bus.iowe = 1'b1;
    irq_ack = 1'b1;
    tick(1);
    bus.iowe = 1'b0;
    irq_ack = 1'b0;
    chk("simul_set_wins", 8'(irq), 8'h01);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("ack_clears", 8'(irq), 8'h00);
    io_rd(8'h00);

    // async reset mid-cycle
    DIC_i = 7'h40;
    tick(3);
    chk("pre_rst_irq", 8'(irq), 8'h01);
    #2;
    ireset = 1'b1;
    #1;
    chk("async_irq", 8'(irq), 8'h00);
    chk("async_pcint", 8'(PCINT_o), 8'h00);
    chk("async_pcie", 8'(PCIE_o), 8'h00);
    DIC_i = 7'h7F;
    tick(2);
    ireset = 1'b0;
    tick(5);
    ram_wr(8'h6C, 8'h7F);
    ram_wr(8'h68, 8'h02);
    tick(5);
    chk("post_rst_irq", 8'(irq), 8'h00);
    io_rd(8'h00);
    ram_rd(8'h6C, 8'h7F);

    tick(2);
    chk("sb_drain", 8'(io_q.size() + ram_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcint_ctrl_c.md
Name: pcint_ctrl_c

Overview:
- Pin-change interrupt controller for the Port C group (PCINT[14:8], group 1).
- Owns the PCMSK1 mask, the PCIE1 enable bit and the PCIF1 flag.
- Drives the PCINT/PCIE1 override inputs of Port_C and samples Port_C's DIC_o.
- Raises an interrupt request toward the core's interrupt unit and clears it by handshake or by software write-one.

Parameters:
N_PINS, 7, number of pin-change lines in the group
SYNC_STAGES, 2, synchronizer depth applied to DIC_i (minimum 1)
PCIFR_IO_ADR, 6'h1B, I/O address of PCIFR
PCICR_RAM_ADR, 8'h68, extended-I/O address of PCICR
PCMSK_RAM_ADR, 8'h6C, extended-I/O address of PCMSK1
PCIE_BIT, 1, bit position of this group in PCICR/PCIFR

Ports:
cp2  in  1  system clock, rising-edge
ireset  in  1  asynchronous, active-high reset
IO_Addr  in  6  core I/O address
iore  in  1  I/O read strobe
iowe  in  1  I/O write strobe
dbus_in  in  8  core write data, shared by the I/O and extended buses
dbus_out  out  8  I/O read data
out_en  out  1  I/O read-data valid
ramadr  in  8  extended-I/O address
ramre  in  1  extended read strobe
ramwe  in  1  extended write strobe
ram_dbus_out  out  8  extended read data
ram_out_en  out  1  extended read-data valid
DIC_i  in  N_PINS  digital input from Port_C (DIC_o)
PCINT_o  out  N_PINS  mask bits to Port_C PCINT input
PCIE_o  out  1  group enable to Port_C PCIE1 input
irq  out  1  interrupt request
irq_ack  in  1  one-cycle acknowledge from the interrupt unit

Behaviour:
- Reset (ireset=1, async):
  - pcmsk, pcie, pcif, sync chain and prev register all go to 0.
  - irq=0, out_en=0, ram_out_en=0, dbus_out=0, ram_dbus_out=0.
- Registers update on the rising edge of cp2.
- Writes act on every rising edge where the strobe and a matching address are high. A strobe held for several cycles simply repeats the write.
  - ramwe & ramadr==PCMSK_RAM_ADR: pcmsk <= dbus_in[N_PINS-1:0].
  - ramwe & ramadr==PCICR_RAM_ADR: pcie <= dbus_in[PCIE_BIT]; other bits ignored.
  - iowe & IO_Addr==PCIFR_IO_ADR & dbus_in[PCIE_BIT]==1: clear pcif (write-one-to-clear). Writing 0 has no effect.
- Reads are combinational:
  - out_en = iore & (IO_Addr==PCIFR_IO_ADR); dbus_out carries pcif at PCIE_BIT and 0 elsewhere.
  - ram_out_en = ramre & address match. PCMSK returns zero-extended pcmsk; PCICR returns pcie at PCIE_BIT and 0 elsewhere.
  - When not enabled, dbus_out and ram_dbus_out are 0. The top level ORs PCIFR contributions from the other groups.
- Synchronizer: DIC_i passes through SYNC_STAGES flops giving s. Register prev <= s every cycle.
- Change detect: chg = (s ^ prev) & pcmsk. Detection is on raw pin values, so a mask write never creates a change by itself.
- Flag update, next pcif:
  - set if |chg;
  - else cleared if (W1C write) or irq_ack;
  - else hold.
  - Set has priority when set and clear occur in the same cycle.
- Flag setting is independent of pcie.
- Output equations:
  - irq = pcif & pcie, driven from registers only.
  - PCINT_o = pcmsk; PCIE_o = pcie.
- Latency: a DIC_i change settled before rising edge k sets pcif at edge k+SYNC_STAGES, so it is visible after SYNC_STAGES+1 edges. irq follows in the same cycle if pcie=1.
- Pulses shorter than one cp2 period may be missed. This is accepted.
- Reset asserted mid-operation drops irq immediately and discards pending changes. After reset, prev equals s, so no spurious flag is raised.

Decomposition:
- Package pcint_pkg holds the address constants (PCIFR_IO_ADR, PCICR_RAM_ADR, PCMSK_RAM_ADR), the group bit indices, and N_PINS defaults for groups 0-3.
- One sub-module, pcint_sync: an N-bit, SYNC_STAGES-deep synchronizer with asynchronous active-high reset to 0.

Test Plan:
- Mask write: ramwe to 8'h6C with 8'h55. Then ramre returns 8'h55, ram_out_en=1, PCINT_o=7'h55, pcif stays 0.
- Masked edge: pcmsk=7'h01, pcie=1, DIC_i[0] 0->1. pcif and irq rise exactly 3 edges later; an IO read of 6'h1B returns 8'h02.
- Unmasked edge: pcmsk=7'h01, toggle DIC_i[6]. pcif remains 0 for 10 cycles and irq stays 0.
- Enable gating and W1C: pcie=0 with a masked toggle gives pcif=1, irq=0. Write PCICR 8'h02 and irq rises next cycle. IO write 6'h1B with 8'h02 clears pcif and irq.
- Simultaneous events: in the same cycle the synchronized change reaches the detector, pulse irq_ack and assert a W1C write. pcif must be 1 afterwards; the next irq_ack alone clears it.
- Async reset: with irq=1, assert ireset mid-cycle. irq, PCINT_o and PCIE_o drop to 0 without a clock edge; after release, static DIC_i=7'h7F produces no flag.
